// File: rtl/audio_pkg.sv
// Shared audio-path constants and the signed sample type used by the
// synth voice chain and its I2S sink.
package audio_pkg;

    localparam int unsigned SAMPLE_W     = 16;
    localparam int unsigned FRAME_CYCLES = 2000;
    localparam int unsigned CLK_HZ       = 96_000_000;
    localparam int unsigned FS_HZ        = 48_000;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Frame timing for the I2S sink: MCLK/BCLK/bit counters, registered codec
// clocks, the once-per-frame sample_tick and the current slot index.
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter int unsigned MCLK_DIV    = 8,
    parameter int unsigned BCLK_HALF   = 20,
    parameter int unsigned BITS_PER_CH = 25,
    parameter int unsigned SLOT_W      = $clog2(BITS_PER_CH)
) (
    input  logic              clk96M,
    input  logic              reset,
    output logic              mclk,
    output logic              bclk,
    output logic              pblrc,
    output logic              sample_tick,
    output logic [SLOT_W-1:0] slot_idx,
    output logic              right_ch
);

    localparam int unsigned BW = $clog2(2 * BCLK_HALF);
    localparam int unsigned NW = $clog2(2 * BITS_PER_CH);
    localparam int unsigned MW = $clog2(MCLK_DIV);

    localparam logic [BW-1:0] BCLK_LAST = BW'(2 * BCLK_HALF - 1);
    localparam logic [BW-1:0] BCLK_MID  = BW'(BCLK_HALF);
    localparam logic [NW-1:0] BIT_LAST  = NW'(2 * BITS_PER_CH - 1);
    localparam logic [NW-1:0] BIT_MID   = NW'(BITS_PER_CH);
    localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_DIV - 1);
    localparam logic [MW-1:0] MCLK_MID  = MW'(MCLK_DIV / 2);

    logic [BW-1:0] bclk_cnt_q, bclk_cnt_d;
    logic [NW-1:0] bit_cnt_q, bit_cnt_d;
    logic [MW-1:0] mclk_cnt_q, mclk_cnt_d;
    logic          mclk_q, mclk_d;
    logic          bclk_q, bclk_d;
    logic          pblrc_q, pblrc_d;
    logic          tick_q, tick_d;
    logic          bclk_wrap;
    logic [NW-1:0] slot_full;

    always_comb begin
        bclk_wrap  = (bclk_cnt_q == BCLK_LAST);
        bclk_cnt_d = bclk_wrap ? '0 : bclk_cnt_q + BW'(1);
        bit_cnt_d  = bit_cnt_q;
        if (bclk_wrap) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + NW'(1);
        end
        mclk_cnt_d = (mclk_cnt_q == MCLK_LAST) ? '0 : mclk_cnt_q + MW'(1);

        mclk_d  = (mclk_cnt_q >= MCLK_MID);
        bclk_d  = (bclk_cnt_q >= BCLK_MID);
        pblrc_d = (bit_cnt_q >= BIT_MID);
        tick_d  = bclk_wrap && (bit_cnt_q == BIT_LAST);

        // Slot info is taken from the live counters so the top's pbdat
        // register lines up with the registered bclk/pblrc.
        right_ch  = pblrc_d;
        slot_full = right_ch ? bit_cnt_q - BIT_MID : bit_cnt_q;
        slot_idx  = SLOT_W'(slot_full);
    end

    always_ff @(posedge clk96M) begin
        if (reset) begin
            bclk_cnt_q <= '0;
            bit_cnt_q  <= '0;
            mclk_cnt_q <= '0;
            mclk_q     <= 1'b0;
            bclk_q     <= 1'b0;
            pblrc_q    <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            bclk_cnt_q <= bclk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            mclk_cnt_q <= mclk_cnt_d;
            mclk_q     <= mclk_d;
            bclk_q     <= bclk_d;
            pblrc_q    <= pblrc_d;
            tick_q     <= tick_d;
        end
    end

    assign mclk        = mclk_q;
    assign bclk        = bclk_q;
    assign pblrc       = pblrc_q;
    assign sample_tick = tick_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips-I2S playback sink for the SSM2603 (codec in slave mode): captures one
// stereo sample per 48 kHz frame and shifts it out MSB first after a 1-bit delay.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W      = SAMPLE_W,
    parameter int unsigned MCLK_DIV    = 8,
    parameter int unsigned BCLK_HALF   = 20,
    parameter int unsigned BITS_PER_CH = 25
) (
    input  logic              clk96M,
    input  logic              reset,
    input  logic [DATA_W-1:0] din_l,
    input  logic [DATA_W-1:0] din_r,
    input  logic              mute,
    output logic              sample_tick,
    output logic              mclk,
    output logic              bclk,
    output logic              pblrc,
    output logic              pbdat
);

    localparam int unsigned SLOT_W = $clog2(BITS_PER_CH);
    localparam int unsigned IW     = $clog2(DATA_W);
    localparam logic [SLOT_W-1:0] DW_S = SLOT_W'(DATA_W);

    generate
        if ((2 * BITS_PER_CH * 2 * BCLK_HALF != FRAME_CYCLES) ||
            (BITS_PER_CH < DATA_W + 1)) begin : g_cfg_err
            $error("i2s_tx: frame timing parameters do not give a valid 2000-cycle frame");
        end
    endgenerate

    logic [SLOT_W-1:0] slot_idx;
    logic              right_ch;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] hold_sel;
    logic [IW-1:0]     bit_idx;
    logic              pbdat_q, pbdat_d;

    i2s_clkgen #(
        .MCLK_DIV    (MCLK_DIV),
        .BCLK_HALF   (BCLK_HALF),
        .BITS_PER_CH (BITS_PER_CH),
        .SLOT_W      (SLOT_W)
    ) u_clkgen (
        .clk96M      (clk96M),
        .reset       (reset),
        .mclk        (mclk),
        .bclk        (bclk),
        .pblrc       (pblrc),
        .sample_tick (sample_tick),
        .slot_idx    (slot_idx),
        .right_ch    (right_ch)
    );

    always_comb begin
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        if (sample_tick) begin
            hold_l_d = mute ? '0 : din_l;
            hold_r_d = mute ? '0 : din_r;
        end

        // Holds change while slot 0 is live, so pbdat still only moves with bclk falling.
        hold_sel = right_ch ? hold_r_q : hold_l_q;
        bit_idx  = IW'(DW_S - slot_idx);
        pbdat_d  = 1'b0;
        if ((slot_idx != '0) && (slot_idx <= DW_S)) begin
            pbdat_d = hold_sel[bit_idx];
        end
    end

    always_ff @(posedge clk96M) begin
        if (reset) begin
            hold_l_q <= '0;
            hold_r_q <= '0;
            pbdat_q  <= 1'b0;
        end else begin
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            pbdat_q  <= pbdat_d;
        end
    end

    assign pbdat = pbdat_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: arithmetic frame-timing model checked every
// cycle, plus directed timing, frame-decode, mute, reset and protocol checks.
module tb_i2s_tx;
    import audio_pkg::*;

    logic                clk96M = 1'b0;
    logic                reset  = 1'b1;
    logic [SAMPLE_W-1:0] din_l  = '0;
    logic [SAMPLE_W-1:0] din_r  = '0;
    logic                mute   = 1'b0;
    logic                sample_tick, mclk, bclk, pblrc, pbdat;

    always #5 clk96M = ~clk96M;

    i2s_tx #(
        .DATA_W      (16),
        .MCLK_DIV    (8),
        .BCLK_HALF   (20),
        .BITS_PER_CH (25)
    ) dut (
        .clk96M      (clk96M),
        .reset       (reset),
        .din_l       (din_l),
        .din_r       (din_r),
        .mute        (mute),
        .sample_tick (sample_tick),
        .mclk        (mclk),
        .bclk        (bclk),
        .pblrc       (pblrc),
        .pbdat       (pbdat)
    );

    int n     = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Sample captured at the tick that opens frame k (tick cycle = 2000*k).
    logic [15:0] cap_l [0:31];
    logic [15:0] cap_r [0:31];

    bit   have_prev;
    logic prev_bclk, prev_pblrc, prev_pbdat;
    int   dec_lo = 1;
    int   dec_hi = 0;
    bit   dec_q[$];
    int   tick_log[$];
    bit   mon_en = 1'b0;
    bit   mon_started;
    int   mon_rises, mon_bad_dat, mon_bad_lrc;

    function automatic logic m_mclk(int c);
        return (c >= 1) && (((c - 1) % 8) >= 4);
    endfunction

    function automatic logic m_bclk(int c);
        return (c >= 1) && (((c - 1) % 40) >= 20);
    endfunction

    function automatic logic m_pblrc(int c);
        return (c >= 1) && (((c - 1) % 2000) >= 1000);
    endfunction

    function automatic logic m_tick(int c);
        return (c >= 1) && (((c - 1) % 2000) == 1999);
    endfunction

    function automatic logic m_pbdat(int c);
        int k, slot, s;
        logic [15:0] smp;
        if (c < 1) return 1'b0;
        k    = (c - 1) / 2000;
        slot = ((c - 1) % 2000) / 40;
        s    = slot % 25;
        if (k == 0 || s == 0 || s > 16) return 1'b0;
        smp = (slot >= 25) ? cap_r[5'(k)] : cap_l[5'(k)];
        return smp[4'(16 - s)];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @n=%0d: observed %b, expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @n=%0d: observed %h, expected %h", tag, n, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @n=%0d: observed %0d, expected %0d", tag, n, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            cap_l[i] = '0;
            cap_r[i] = '0;
        end
        have_prev   = 1'b0;
        mon_started = 1'b0;
        mon_rises   = 0;
        dec_q.delete();
        tick_log.delete();
    endtask

    task automatic sample_and_check();
        chk("mclk", mclk, m_mclk(n));
        chk("bclk", bclk, m_bclk(n));
        chk("pblrc", pblrc, m_pblrc(n));
        chk("sample_tick", sample_tick, m_tick(n));
        chk("pbdat", pbdat, m_pbdat(n));
        if (sample_tick === 1'b1) tick_log.push_back(n);
        if (have_prev && n >= dec_lo && n <= dec_hi && !prev_bclk && bclk)
            dec_q.push_back(pbdat);
        if (mon_en && have_prev) begin
            if (prev_bclk && bclk && (pbdat !== prev_pbdat)) mon_bad_dat++;
            if ((pblrc !== prev_pblrc) && !(prev_bclk && !bclk)) mon_bad_lrc++;
            if (!prev_bclk && bclk) mon_rises++;
            if (sample_tick === 1'b1) begin
                if (mon_started) chk_int("rises_per_frame", mon_rises, 50);
                mon_started = 1'b1;
                mon_rises   = 0;
            end
        end
        prev_bclk  = bclk;
        prev_pblrc = pblrc;
        prev_pbdat = pbdat;
        have_prev  = 1'b1;
    endtask

    task automatic cyc(input logic [15:0] l, input logic [15:0] r, input logic m);
        @(posedge clk96M);
        #1;
        n++;
        din_l = l;
        din_r = r;
        mute  = m;
        if (m_tick(n)) begin
            cap_l[5'(n / 2000)] = m ? 16'h0000 : l;
            cap_r[5'(n / 2000)] = m ? 16'h0000 : r;
        end
        #3;
        sample_and_check();
    endtask

    task automatic run_to(input int target, input logic [15:0] l, input logic [15:0] r, input logic m);
        while (n < target) cyc(l, r, m);
    endtask

    task automatic enter_cycle0();
        @(posedge clk96M);
        #1;
        reset = 1'b0;
        n     = 0;
        clear_model();
        #3;
        chk("rst_mclk", mclk, 1'b0);
        chk("rst_bclk", bclk, 1'b0);
        chk("rst_pblrc", pblrc, 1'b0);
        chk("rst_tick", sample_tick, 1'b0);
        chk("rst_pbdat", pbdat, 1'b0);
        sample_and_check();
    endtask

    task automatic reset_pulse();
        @(posedge clk96M);
        #1;
        n++;
        reset = 1'b1;
        #3;
        sample_and_check();
        enter_cycle0();
    endtask

    task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
        logic [15:0] l, r;
        logic pad;
        l   = '0;
        r   = '0;
        pad = 1'b0;
        chk_int({tag, "_nbits"}, dec_q.size(), 50);
        if (dec_q.size() == 50) begin
            for (int j = 0; j < 50; j++) begin
                if (j >= 1 && j <= 16)       l = {l[14:0], dec_q[j]};
                else if (j >= 26 && j <= 41) r = {r[14:0], dec_q[j]};
                else                         pad = pad | dec_q[j];
            end
            chk16({tag, "_left"}, l, el);
            chk16({tag, "_right"}, r, er);
            chk({tag, "_pad"}, pad, 1'b0);
        end
        dec_q.delete();
    endtask

    initial begin
        din_l = 16'hA5F0;
        din_r = 16'h0F5A;
        repeat (4) @(posedge clk96M);
        enter_cycle0();

        // Timing from reset release, frame 2 decode window armed in advance.
        dec_lo = 4001;
        dec_hi = 6000;
        run_to(4, 16'hA5F0, 16'h0F5A, 1'b0);    chk("t1_mclk4", mclk, 1'b0);
        run_to(5, 16'hA5F0, 16'h0F5A, 1'b0);    chk("t1_mclk5", mclk, 1'b1);
        run_to(9, 16'hA5F0, 16'h0F5A, 1'b0);    chk("t1_mclk9", mclk, 1'b0);
        run_to(13, 16'hA5F0, 16'h0F5A, 1'b0);   chk("t1_mclk13", mclk, 1'b1);
        run_to(20, 16'hA5F0, 16'h0F5A, 1'b0);   chk("t1_bclk20", bclk, 1'b0);
        run_to(21, 16'hA5F0, 16'h0F5A, 1'b0);   chk("t1_bclk21", bclk, 1'b1);
        run_to(41, 16'hA5F0, 16'h0F5A, 1'b0);   chk("t1_bclk41", bclk, 1'b0);
        run_to(61, 16'hA5F0, 16'h0F5A, 1'b0);   chk("t1_bclk61", bclk, 1'b1);
        run_to(1000, 16'hA5F0, 16'h0F5A, 1'b0); chk("t1_pblrc1000", pblrc, 1'b0);
        run_to(1001, 16'hA5F0, 16'h0F5A, 1'b0); chk("t1_pblrc1001", pblrc, 1'b1);
        run_to(4000, 16'hA5F0, 16'h0F5A, 1'b0);
        chk_int("t1_tick_count", tick_log.size(), 2);
        if (tick_log.size() == 2) begin
            chk_int("t1_tick0", tick_log[0], 2000);
            chk_int("t1_tick1", tick_log[1], 4000);
        end

        // Constant pattern, then inputs change one cycle after the tick.
        run_to(5998, 16'hA5F0, 16'h0F5A, 1'b0);
        run_to(6000, 16'h8000, 16'h7FFF, 1'b0);
        check_frame("t2", 16'hA5F0, 16'h0F5A);
        dec_lo = 6001;
        dec_hi = 8000;
        run_to(7999, 16'h1234, 16'h1234, 1'b0);
        cyc(16'hFFFF, 16'hFFFF, 1'b1);
        check_frame("t3", 16'h8000, 16'h7FFF);

        // Mute only in the tick cycle, then an unmuted tick.
        dec_lo = 8001;
        dec_hi = 10000;
        run_to(10000, 16'hFFFF, 16'hFFFF, 1'b0);
        check_frame("t4_muted", 16'h0000, 16'h0000);
        dec_lo = 10001;
        dec_hi = 12000;
        run_to(12000, 16'hFFFF, 16'hFFFF, 1'b0);
        check_frame("t4_unmuted", 16'hFFFF, 16'hFFFF);

        // One-cycle reset at frame position 700.
        run_to(12699, 16'h1357, 16'h2468, 1'b0);
        reset_pulse();
        dec_lo = 1;
        dec_hi = 2000;
        run_to(20, 16'hC3C3, 16'h3C3C, 1'b0);   chk("t5_bclk20", bclk, 1'b0);
        run_to(21, 16'hC3C3, 16'h3C3C, 1'b0);   chk("t5_bclk21", bclk, 1'b1);
        run_to(1000, 16'hC3C3, 16'h3C3C, 1'b0); chk("t5_pblrc1000", pblrc, 1'b0);
        run_to(1001, 16'hC3C3, 16'h3C3C, 1'b0); chk("t5_pblrc1001", pblrc, 1'b1);
        run_to(2000, 16'hC3C3, 16'h3C3C, 1'b0);
        chk_int("t5_tick_count", tick_log.size(), 1);
        if (tick_log.size() == 1) chk_int("t5_tick0", tick_log[0], 2000);
        check_frame("t5_silent", 16'h0000, 16'h0000);
        dec_lo = 2001;
        dec_hi = 4000;
        run_to(4000, 16'hC3C3, 16'h3C3C, 1'b0);
        check_frame("t5_frame1", 16'hC3C3, 16'h3C3C);

        // Randomised data and mute with the protocol monitor running.
        dec_lo      = 1;
        dec_hi      = 0;
        mon_bad_dat = 0;
        mon_bad_lrc = 0;
        mon_en      = 1'b1;
        while (n < 28000)
            cyc(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
        chk_int("t6_pbdat_while_bclk_high", mon_bad_dat, 0);
        chk_int("t6_pblrc_off_bclk_fall", mon_bad_lrc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
